dcache_lsu: RTL and testbench
=============================

// Module: dcache_lsu
// PURPOSE
//  Parametrised successor to the single-cycle word data cache, sitting between execute and the data RAM.
//  Adds byte, halfword and word loads and stores, with sign or zero extension on loads.
//  Adds an alignment-fault response and a valid/ready request/response handshake with back-pressure.
//  One access per cycle; responses come back in order, one cycle after the request is accepted.
// PARAMETERS
//  ADDR_W     7        byte-address width; the RAM holds 2**(ADDR_W-2) 32-bit words
//  STR_UOP    4'b1001  store word
//  LDR_UOP    4'b1010  load word
//  STRB_UOP   4'b1011  store byte (data_in[7:0])
//  LDRB_UOP   4'b1100  load byte, zero-extended
//  STRH_UOP   4'b1101  store halfword (data_in[15:0])
//  LDRH_UOP   4'b1110  load halfword, zero-extended
//  LDRSB_UOP  4'b1111  load byte, sign-extended
//  LDRSH_UOP  4'b1000  load halfword, sign-extended
// PORTS
//  clock       in   1       single clock; all state updates on the rising edge
//  reset_n     in   1       asynchronous active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when req_valid && req_ready at the rising edge
//  addr        in   ADDR_W  byte address
//  data_in     in   32      store data, right-aligned
//  uop         in   4       operation code
//  resp_valid  out  1       response present
//  resp_ready  in   1       response consumed when resp_valid && resp_ready at the rising edge
//  resp_fault  out  1       access was misaligned; no memory effect
//  data_out    out  32      load result; 0 for stores and faults
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, resp_valid=0, resp_fault=0, data_out=0.
//    RAM contents are NOT cleared and survive a reset. A pending response is discarded.
//  - FSM
//    IDLE: req_ready=1. An accepted memory uop moves to RESP.
//    RESP: resp_valid=1. req_ready=resp_ready.
//      resp_ready=1 with a new accepted memory uop: stay in RESP with the new response (back-to-back).
//      resp_ready=1 and nothing new accepted: go to IDLE.
//      resp_ready=0: hold every response output stable.
//  - Latency: a request accepted at edge N has its response valid from edge N to edge N+1, i.e. 1 cycle.
//  - Word index is addr[ADDR_W-1:2]; the byte lane is addr[1:0].
//  - Stores write only the selected lanes, at the accept edge:
//    STRB writes 1 lane; STRH writes lanes {addr[1],0} and {addr[1],1}; STR writes 4 lanes.
//    Store response: resp_fault=0, data_out=0.
//  - Loads perform a synchronous RAM read at the accept edge.
//    The selected byte or halfword is shifted to bit 0, then zero- or sign-extended to 32 bits.
//  - A store accepted at edge N is visible to a load accepted at edge N+1 (no extra forwarding logic).
//  - Alignment: halfword ops with addr[0]=1, and word ops with addr[1:0]!=0, are faults.
//    A fault gives no RAM write and a response with resp_fault=1, data_out=0.
//  - Non-memory uop with req_valid=1: accepted (req_ready as above), no response, no state change.
//    Matches the existing rule that the cache ignores non-memory uops.
//  - Reset asserted mid-response: the response is lost; any store already accepted stays written.
// STRUCTURE
//  - uop_defs.vh (shared `include): the eight uop encodings plus localparams for the access sizes.
//    Execute and decode use the same file.
//  - Sub-module dcache_align, combinational:
//    store path: builds byte-enable[3:0] and the lane-replicated write word;
//    load path: lane extract plus extension.
//  - The top level holds the FSM, the response registers and the RAM array (reg [31:0] mem[0:2**(ADDR_W-2)-1]).
// TESTING
//  1 Reset: reset_n=0 mid-cycle -> resp_valid=0, data_out=0, req_ready=0 until release, then req_ready=1.
//  2 Word: STR 0x12345678 @0x28, then LDR @0x28 -> data_out=0x12345678, resp_fault=0, resp_valid 1 cycle after accept.
//  3 Lanes: STR 0xAABBCCDD @0x14, STRB 0x11 @0x15, then:
//      LDR   @0x14 -> 0xAABB11DD
//      LDRSB @0x17 -> 0xFFFFFFAA
//      LDRB  @0x17 -> 0x000000AA
//      LDRSH @0x16 -> 0xFFFFAABB
//  4 Fault: STRH @0x03 -> resp_fault=1, data_out=0; LDR @0x00 shows the word unchanged.
//    LDR @0x02 -> resp_fault=1.
//  5 Back-pressure: hold resp_ready=0 for 3 cycles after a load -> resp_valid and data_out stable, req_ready=0.
//    Release -> a queued request is accepted the same cycle.
//    Back-to-back loads with resp_ready=1 -> one response per cycle.
//  6 Ignore: uop=4'b0010 with req_valid=1 -> no response, RAM unchanged.

Source files
------------

// File: rtl/dcache_lsu_pkg.sv
// Shared definitions for the load/store data cache: uop encodings, access sizes, FSM states.
// Execute and decode import the same encodings so the opcode map lives in one place.
package dcache_lsu_pkg;

    localparam int DEF_ADDR_W = 7;

    localparam logic [3:0] STR_UOP   = 4'b1001;
    localparam logic [3:0] LDR_UOP   = 4'b1010;
    localparam logic [3:0] STRB_UOP  = 4'b1011;
    localparam logic [3:0] LDRB_UOP  = 4'b1100;
    localparam logic [3:0] STRH_UOP  = 4'b1101;
    localparam logic [3:0] LDRH_UOP  = 4'b1110;
    localparam logic [3:0] LDRSB_UOP = 4'b1111;
    localparam logic [3:0] LDRSH_UOP = 4'b1000;

    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_e;
    typedef enum logic {IDLE, RESP} state_e;

    typedef struct packed {
        logic  mem;
        logic  store;
        logic  sext;
        size_e size;
    } uop_info_t;

    function automatic uop_info_t decode_uop(input logic [3:0] uop);
        uop_info_t info;
        info = '{mem: 1'b1, store: 1'b0, sext: 1'b0, size: SIZE_WORD};
        case (uop)
            STR_UOP:   info.store = 1'b1;
            LDR_UOP:   info.size  = SIZE_WORD;
            STRB_UOP:  begin info.store = 1'b1; info.size = SIZE_BYTE; end
            LDRB_UOP:  info.size = SIZE_BYTE;
            STRH_UOP:  begin info.store = 1'b1; info.size = SIZE_HALF; end
            LDRH_UOP:  info.size = SIZE_HALF;
            LDRSB_UOP: begin info.sext = 1'b1; info.size = SIZE_BYTE; end
            LDRSH_UOP: begin info.sext = 1'b1; info.size = SIZE_HALF; end
            default:   info.mem = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/dcache_lsu_if.sv
// Request/response handshake bundle between execute (master) and the data cache (slave).
interface dcache_lsu_if #(parameter int ADDR_W = dcache_lsu_pkg::DEF_ADDR_W);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [3:0]        uop;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_fault;
    logic [31:0]       data_out;

    modport master (
        output req_valid, addr, data_in, uop, resp_ready,
        input  req_ready, resp_valid, resp_fault, data_out
    );

    modport slave (
        input  req_valid, addr, data_in, uop, resp_ready,
        output req_ready, resp_valid, resp_fault, data_out
    );
endinterface

// File: rtl/dcache_lsu_align.sv
// Combinational lane logic: store byte-enables and replicated write word, load extract and
// extension, and the misalignment check.
module dcache_lsu_align
    import dcache_lsu_pkg::*;
(
    input  uop_info_t   info,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        fault,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);
    logic [31:0] shifted;

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        fault   = 1'b0;
        be      = 4'b0000;
        wword   = wdata;
        rdata   = rword;
        shifted = rword >> {lane, 3'b000};
        case (info.size)
            SIZE_BYTE: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
                rdata = {{24{info.sext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                fault = lane[0];
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                rdata = {{16{info.sext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                fault = (lane != 2'b00);
                be    = 4'b1111;
            end
        endcase
        fault = fault & info.mem;
    end

endmodule

// File: rtl/dcache_lsu.sv
// Load/store data cache: one access per cycle, response registered one cycle after accept,
// held stable under back-pressure.
module dcache_lsu
    import dcache_lsu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic         clock,
    input logic         reset_n,
    dcache_lsu_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0]       mem [DEPTH];
    state_e            state, next_state;
    uop_info_t         info;
    logic [ADDR_W-3:0] idx;
    logic              accept, mem_accept, fault, wr_en;
    logic [3:0]        be;
    logic [31:0]       wword, rdata;
    logic              fault_q;
    logic [31:0]       data_q;

    assign info = decode_uop(bus.uop);
    assign idx  = bus.addr[ADDR_W-1:2];

    dcache_lsu_align u_align (
        .info  (info),
        .lane  (bus.addr[1:0]),
        .wdata (bus.data_in),
        .rword (mem[idx]),
        .fault (fault),
        .be    (be),
        .wword (wword),
        .rdata (rdata)
    );

    // Ready is forced low while reset is held so nothing is accepted during reset.
    assign bus.req_ready  = reset_n && ((state == IDLE) || bus.resp_ready);
    assign accept         = bus.req_valid && bus.req_ready;
    assign mem_accept     = accept && info.mem;
    assign wr_en          = mem_accept && info.store && !fault;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_fault = fault_q;
    assign bus.data_out   = data_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (mem_accept) next_state = RESP;
            RESP: if (bus.resp_ready) next_state = mem_accept ? RESP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            fault_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state <= next_state;
            if (mem_accept) begin
                fault_q <= fault;
                data_q  <= (info.store || fault) ? 32'h0 : rdata;
            end
        end
    end

    // NOTE: the RAM has no reset; its contents survive reset and a reset would block RAM inference.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wword[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_lsu.sv
// Directed self-checking bench for dcache_lsu: reset, word and lane access, faults,
// back-pressure, back-to-back traffic and non-memory uops.
module tb_dcache_lsu;
    import dcache_lsu_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    dcache_lsu_if #(.ADDR_W(7)) bus ();

    dcache_lsu #(.ADDR_W(7)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one request for exactly one edge; the response is sampled 1 time unit later.
    task automatic issue(input logic [3:0] u, input logic [6:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.uop       = u;
        bus.addr      = a;
        bus.data_in   = d;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic f, input logic [31:0] d);
        check({tag, ".valid"}, {31'b0, bus.resp_valid}, 32'h1);
        check({tag, ".fault"}, {31'b0, bus.resp_fault}, {31'b0, f});
        check({tag, ".data"},  bus.data_out, d);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        bus.uop        = 4'b0000;
        bus.addr       = '0;
        bus.data_in    = '0;

        // Reset held: outputs cleared and nothing accepted.
        #12;
        check("rst.valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rst.data",  bus.data_out, 32'h0);
        check("rst.ready", {31'b0, bus.req_ready}, 32'h0);
        step();
        reset_n = 1'b1;
        #1;
        check("rst.ready_rel", {31'b0, bus.req_ready}, 32'h1);

        // Word store and load; response lasts exactly one cycle.
        issue(STR_UOP, 7'h28, 32'h1234_5678);
        check_resp("str28", 1'b0, 32'h0);
        issue(LDR_UOP, 7'h28, 32'h0);
        check_resp("ldr28", 1'b0, 32'h1234_5678);
        step();
        check("ldr28.drop", {31'b0, bus.resp_valid}, 32'h0);

        // Byte lanes and extension.
        issue(STR_UOP,  7'h14, 32'hAABB_CCDD);
        issue(STRB_UOP, 7'h15, 32'hFFFF_FF11);
        check_resp("strb15", 1'b0, 32'h0);
        issue(LDR_UOP,   7'h14, 32'h0); check_resp("ldr14",   1'b0, 32'hAABB_11DD);
        issue(LDRSB_UOP, 7'h17, 32'h0); check_resp("ldrsb17", 1'b0, 32'hFFFF_FFAA);
        issue(LDRB_UOP,  7'h17, 32'h0); check_resp("ldrb17",  1'b0, 32'h0000_00AA);
        issue(LDRSH_UOP, 7'h16, 32'h0); check_resp("ldrsh16", 1'b0, 32'hFFFF_AABB);
        issue(LDRH_UOP,  7'h14, 32'h0); check_resp("ldrh14",  1'b0, 32'h0000_11DD);
        issue(LDRSB_UOP, 7'h14, 32'h0); check_resp("ldrsb14", 1'b0, 32'hFFFF_FFDD);

        // Misalignment faults leave memory untouched.
        issue(STR_UOP,  7'h00, 32'hCAFE_F00D);
        issue(STRH_UOP, 7'h03, 32'h0000_BEEF); check_resp("strh03", 1'b1, 32'h0);
        issue(LDR_UOP,  7'h00, 32'h0);         check_resp("ldr00",  1'b0, 32'hCAFE_F00D);
        issue(LDR_UOP,  7'h02, 32'h0);         check_resp("ldr02",  1'b1, 32'h0);
        issue(LDRH_UOP, 7'h01, 32'h0);         check_resp("ldrh01", 1'b1, 32'h0);
        step();

        // Back-pressure: response held, queued request waits, then goes the cycle ready returns.
        bus.resp_ready = 1'b0;
        issue(LDR_UOP, 7'h28, 32'h0);
        check_resp("bp.first", 1'b0, 32'h1234_5678);
        bus.req_valid = 1'b1;
        bus.uop       = LDR_UOP;
        bus.addr      = 7'h14;
        #1;
        check("bp.ready0", {31'b0, bus.req_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_resp("bp.hold", 1'b0, 32'h1234_5678);
            check("bp.ready", {31'b0, bus.req_ready}, 32'h0);
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp.ready1", {31'b0, bus.req_ready}, 32'h1);
        step();
        bus.req_valid = 1'b0;
        check_resp("bp.queued", 1'b0, 32'hAABB_11DD);

        // Back-to-back loads: one response per cycle.
        issue(LDR_UOP,  7'h00, 32'h0); check_resp("b2b.0", 1'b0, 32'hCAFE_F00D);
        issue(LDR_UOP,  7'h28, 32'h0); check_resp("b2b.1", 1'b0, 32'h1234_5678);
        issue(LDRB_UOP, 7'h15, 32'h0); check_resp("b2b.2", 1'b0, 32'h0000_0011);
        step();
        check("b2b.drop", {31'b0, bus.resp_valid}, 32'h0);

        // Non-memory uops: accepted, no response, no write.
        issue(4'b0010, 7'h28, 32'hDEAD_BEEF);
        check("nomem.valid", {31'b0, bus.resp_valid}, 32'h0);
        issue(4'b0001, 7'h28, 32'hDEAD_BEEF);
        check("nomem.valid2", {31'b0, bus.resp_valid}, 32'h0);
        issue(LDR_UOP, 7'h28, 32'h0); check_resp("nomem.ldr", 1'b0, 32'h1234_5678);
        step();

        // Reset mid-response: response lost, accepted store and earlier RAM contents kept.
        issue(STR_UOP, 7'h30, 32'h55AA_55AA);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.valid", {31'b0, bus.resp_valid}, 32'h0);
        check("midrst.fault", {31'b0, bus.resp_fault}, 32'h0);
        check("midrst.ready", {31'b0, bus.req_ready}, 32'h0);
        step();
        reset_n = 1'b1;
        #1;
        issue(LDR_UOP, 7'h30, 32'h0); check_resp("midrst.ldr30", 1'b0, 32'h55AA_55AA);
        issue(LDR_UOP, 7'h28, 32'h0); check_resp("midrst.ldr28", 1'b0, 32'h1234_5678);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
